// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-lite SRAM slave with wait states, byte-lane writes and two-cycle ERROR
// Optional: define AHB_SRAM_ALIGN_CHECK_EN to reject unaligned halfword/word transfers with ERROR
module ahb_sram_slave #(
    parameter int P_ADDR_BITS = 12,
    parameter int P_DELAY     = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic [1:0]  HRESP,
    output logic        HREADYout
);

    localparam int         WORD_BITS  = P_ADDR_BITS - 2;
    localparam int         NUM_WORDS  = 2 ** WORD_BITS;
    localparam logic [1:0] RESP_OKAY  = 2'd0;
    localparam logic [1:0] RESP_ERROR = 2'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_XFER,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                 state;
    logic [3:0]             wait_cnt;
    logic [P_ADDR_BITS-1:0] lat_offset;
    logic                   lat_write;
    logic [2:0]             lat_size;

    logic [31:0]            mem [NUM_WORDS];

    logic                   accept_slot;
    logic                   capture;
    logic                   size_ok;
    logic                   align_ok;
    logic                   legal;
    logic [P_ADDR_BITS-1:0] aligned_offset;
    state_t                 cap_state;
    logic [3:0]             lane_en;
    logic [WORD_BITS-1:0]   word_idx;

    // Upper address bits are decoded by the interconnect; burst type and HTRANS[0] carry no meaning here
    logic unused_inputs;
    assign unused_inputs = ^{HADDR[31:P_ADDR_BITS], HTRANS[0], HBURST};

    // Address-phase decode: capture condition, legality and the state a capture leads to
    always_comb begin
        accept_slot = (state == S_IDLE) || (state == S_XFER) || (state == S_ERR2);
        capture     = accept_slot && HSEL && HREADY && HTRANS[1];
        size_ok     = (HSIZE <= 3'd2);
`ifdef AHB_SRAM_ALIGN_CHECK_EN
        align_ok    = !(((HSIZE == 3'd1) && HADDR[0]) ||
                        ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00)));
`else
        align_ok    = 1'b1;
`endif
        legal       = size_ok && align_ok;

        // Low bits are forced to natural alignment; with the check enabled only aligned ones get here
        aligned_offset = HADDR[P_ADDR_BITS-1:0];
        if (HSIZE == 3'd1) begin
            aligned_offset[0] = 1'b0;
        end else if (HSIZE == 3'd2) begin
            aligned_offset[1:0] = 2'b00;
        end

        if (!legal) begin
            cap_state = S_ERR1;
        end else if (P_DELAY == 0) begin
            cap_state = S_XFER;
        end else begin
            cap_state = S_WAIT;
        end
    end

    // Transfer FSM with registered HREADYout/HRESP and latched address/control
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state      <= S_IDLE;
            wait_cnt   <= 4'd0;
            lat_offset <= '0;
            lat_write  <= 1'b0;
            lat_size   <= 3'd0;
            HREADYout  <= 1'b1;
            HRESP      <= RESP_OKAY;
        end else begin
            case (state)
                S_WAIT: begin
                    if (wait_cnt <= 4'd1) begin
                        state     <= S_XFER;
                        wait_cnt  <= 4'd0;
                        HREADYout <= 1'b1;
                        HRESP     <= RESP_OKAY;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_ERR1: begin
                    state     <= S_ERR2;
                    HREADYout <= 1'b1;
                    HRESP     <= RESP_ERROR;
                end
                default: begin
                    // IDLE, XFER and ERR2 all present HREADY=1, so a new address phase may land here
                    if (capture) begin
                        state      <= cap_state;
                        wait_cnt   <= 4'(P_DELAY);
                        lat_offset <= aligned_offset;
                        lat_write  <= HWRITE;
                        lat_size   <= HSIZE;
                        HREADYout  <= (cap_state == S_XFER);
                        HRESP      <= legal ? RESP_OKAY : RESP_ERROR;
                    end else begin
                        state     <= S_IDLE;
                        HREADYout <= 1'b1;
                        HRESP     <= RESP_OKAY;
                    end
                end
            endcase
        end
    end

    assign word_idx = lat_offset[P_ADDR_BITS-1:2];

    // Byte-lane enables from the latched size and (already aligned) offset
    always_comb begin
        lane_en = 4'b0000;
        case (lat_size)
            3'd0:    lane_en[lat_offset[1:0]] = 1'b1;
            3'd1:    lane_en = lat_offset[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    // Write commits at the end of the XFER cycle; a reset on that edge discards it
    always_ff @(posedge HCLK) begin
        if (!HRESET && (state == S_XFER) && lat_write) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) begin
                    mem[word_idx][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    // Read data is combinational from the array, so a read right after a write sees the new word
    assign HRDATA = (state == S_XFER) ? mem[word_idx] : 32'd0;

endmodule
